// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
// Stall vectors are indexed by the STG_* stage positions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

  localparam int STG_PC     = 0;
  localparam int STG_IF     = 1;
  localparam int STG_ID     = 2;
  localparam int STG_EX     = 3;
  localparam int STG_MEM    = 4;
  localparam int STG_WB     = 5;
  localparam int NUM_STAGES = 6;

  // A stall holds the stalling stage and every stage upstream of it.
  localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STAGES-1:0] STALL_ID   = 6'b000111;
  localparam logic [NUM_STAGES-1:0] STALL_EX   = 6'b001111;
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall vector, exception flush/redirect,
// branch redirect, stall statistics and a sticky consecutive-stall timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_branch_stall_i,
  input  logic                  id_load_use_i,
  input  logic                  ex_busy_i,
  input  logic                  mem_stall_i,
  input  logic                  exc_valid_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  branch_taken_i,
  input  logic [31:0]           branch_target_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic                  new_pc_valid_o,
  output logic [31:0]           new_pc_o,
  output logic                  exc_ack_o,
  output logic [31:0]           stall_cnt_o,
  output logic                  stall_timeout_o,
  output pipe_state_e           state_o
);

  localparam logic [7:0] LIMIT8 = STALL_LIMIT[7:0];

  pipe_state_e            state_q, state_d;
  logic [31:0]            exc_pc_q, exc_pc_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [7:0]             consec_q, consec_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_STAGES-1:0]  stall_vec;
  logic                   stalled;
  logic                   in_flush;
  logic                   exc_acc;
  logic                   br_redir;

  // Exception handshake: exc_valid_i is held by the source until exc_ack_o
  // pulses for one cycle; acceptance is deferred while the data bus waits.
  always_comb begin
    stall_vec = STALL_NONE;
    in_flush  = !rst_i && (state_q == ST_FLUSH);
    if (rst_i || state_q == ST_FLUSH)              stall_vec = STALL_NONE;
    else if (mem_stall_i)                          stall_vec = STALL_MEM;
    else if (ex_busy_i)                            stall_vec = STALL_EX;
    else if (id_branch_stall_i || id_load_use_i)   stall_vec = STALL_ID;
    stalled  = (stall_vec != STALL_NONE);
    exc_acc  = !rst_i && (state_q != ST_FLUSH) && exc_valid_i && !mem_stall_i;
    br_redir = !rst_i && (state_q != ST_FLUSH) && branch_taken_i && !stalled && !exc_acc;
  end

  always_comb begin
    state_d   = state_q;
    exc_pc_d  = exc_pc_q;
    cnt_d     = cnt_q;
    consec_d  = consec_q;
    timeout_d = timeout_q;

    if (exc_acc)                   state_d = ST_FLUSH;
    else if (state_q == ST_FLUSH)  state_d = ST_RUN;
    else if (stalled)              state_d = ST_STALL;
    else                           state_d = ST_RUN;

    if (exc_acc) exc_pc_d = exc_pc_i;

    if (stalled) begin
      cnt_d    = cnt_q + 32'd1;
      consec_d = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
      if (consec_d == LIMIT8) timeout_d = 1'b1;
    end else begin
      consec_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      exc_pc_q  <= 32'd0;
      cnt_q     <= 32'd0;
      consec_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exc_pc_q  <= exc_pc_d;
      cnt_q     <= cnt_d;
      consec_q  <= consec_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_o         = stall_vec;
  assign flush_o         = in_flush;
  assign new_pc_valid_o  = in_flush || br_redir;
  assign new_pc_o        = in_flush ? exc_pc_q : (br_redir ? branch_target_i : 32'd0);
  assign exc_ack_o       = exc_acc;
  assign stall_cnt_o     = cnt_q;
  assign stall_timeout_o = timeout_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change just after the rising edge,
// outputs are checked on the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_branch_stall_i, id_load_use_i, ex_busy_i, mem_stall_i;
  logic        exc_valid_i, branch_taken_i;
  logic [31:0] exc_pc_i, branch_target_i;
  logic [5:0]  stall_o;
  logic        flush_o, new_pc_valid_o, exc_ack_o, stall_timeout_o;
  logic [31:0] new_pc_o, stall_cnt_o;
  pipe_state_e state_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.STALL_LIMIT(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_branch_stall_i(id_branch_stall_i), .id_load_use_i(id_load_use_i),
    .ex_busy_i(ex_busy_i), .mem_stall_i(mem_stall_i),
    .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_valid_o(new_pc_valid_o),
    .new_pc_o(new_pc_o), .exc_ack_o(exc_ack_o), .stall_cnt_o(stall_cnt_o),
    .stall_timeout_o(stall_timeout_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_branch_stall_i = 1'b0; id_load_use_i = 1'b0;
    ex_busy_i = 1'b0; mem_stall_i = 1'b0;
    exc_valid_i = 1'b0; exc_pc_i = 32'd0;
    branch_taken_i = 1'b0; branch_target_i = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_stall"}, 32'(stall_o), 32'(6'b000000));
    check_eq({tag, "_flush"}, 32'(flush_o), 32'd0);
    check_eq({tag, "_npv"},   32'(new_pc_valid_o), 32'd0);
    check_eq({tag, "_npc"},   new_pc_o, 32'd0);
    check_eq({tag, "_ack"},   32'(exc_ack_o), 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_idle("rst");
    check_eq("rst_cnt", stall_cnt_o, 32'd0);
    check_eq("rst_tmo", 32'(stall_timeout_o), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'(ST_RUN));
    rst_i = 1'b0;
    next_cycle();

    // single ID branch stall
    id_branch_stall_i = 1'b1;
    mid();
    check_eq("id_stall", 32'(stall_o), 32'(6'b000111));
    check_eq("id_cnt0", stall_cnt_o, 32'd0);
    next_cycle();
    id_branch_stall_i = 1'b0;
    mid();
    check_eq("id_cnt1", stall_cnt_o, 32'd1);
    check_eq("id_st_stall", 32'(state_o), 32'(ST_STALL));
    check_eq("id_unstall", 32'(stall_o), 32'd0);
    next_cycle();
    id_load_use_i = 1'b1;
    mid();
    check_eq("id_st_run", 32'(state_o), 32'(ST_RUN));
    check_eq("lu_stall", 32'(stall_o), 32'(6'b000111));
    next_cycle();
    id_load_use_i = 1'b0;
    mid();
    check_eq("lu_cnt", stall_cnt_o, 32'd2);

    // exception deferred by memory stall, then accepted and flushed
    next_cycle();
    exc_valid_i = 1'b1; exc_pc_i = 32'h0000_0380; mem_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      check_eq("exc_defer_ack", 32'(exc_ack_o), 32'd0);
      check_eq("exc_defer_stall", 32'(stall_o), 32'(6'b011111));
      next_cycle();
    end
    mem_stall_i = 1'b0;
    mid();
    check_eq("exc_ack", 32'(exc_ack_o), 32'd1);
    check_eq("exc_ack_npv", 32'(new_pc_valid_o), 32'd0);
    next_cycle();
    mid();
    check_eq("flush_state", 32'(state_o), 32'(ST_FLUSH));
    check_eq("flush_o", 32'(flush_o), 32'd1);
    check_eq("flush_npv", 32'(new_pc_valid_o), 32'd1);
    check_eq("flush_npc", new_pc_o, 32'h0000_0380);
    check_eq("flush_no_ack", 32'(exc_ack_o), 32'd0);
    check_eq("flush_stall", 32'(stall_o), 32'd0);
    check_eq("flush_cnt", stall_cnt_o, 32'd4);
    next_cycle();
    exc_valid_i = 1'b0; exc_pc_i = 32'd0;
    mid();
    check_eq("post_flush_state", 32'(state_o), 32'(ST_RUN));
    check_idle("post_flush");

    // branch held off by EX busy, taken once the stall clears
    next_cycle();
    branch_taken_i = 1'b1; branch_target_i = 32'h8000_1000; ex_busy_i = 1'b1;
    mid();
    check_eq("br_busy_stall", 32'(stall_o), 32'(6'b001111));
    check_eq("br_busy_npv", 32'(new_pc_valid_o), 32'd0);
    check_eq("br_busy_npc", new_pc_o, 32'd0);
    next_cycle();
    ex_busy_i = 1'b0;
    mid();
    check_eq("br_npv", 32'(new_pc_valid_o), 32'd1);
    check_eq("br_npc", new_pc_o, 32'h8000_1000);
    check_eq("br_flush", 32'(flush_o), 32'd0);
    check_eq("br_cnt", stall_cnt_o, 32'd5);
    next_cycle();
    branch_taken_i = 1'b0; branch_target_i = 32'd0;
    mid();
    check_idle("br_done");

    // exception beats a simultaneous branch
    next_cycle();
    exc_valid_i = 1'b1; exc_pc_i = 32'h0000_0400;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_1234;
    mid();
    check_eq("race_ack", 32'(exc_ack_o), 32'd1);
    check_eq("race_npv", 32'(new_pc_valid_o), 32'd0);
    check_eq("race_npc", new_pc_o, 32'd0);
    next_cycle();
    clear_inputs();
    mid();
    check_eq("race_state", 32'(state_o), 32'(ST_FLUSH));
    check_eq("race_flush_npc", new_pc_o, 32'h0000_0400);
    check_eq("race_flush", 32'(flush_o), 32'd1);
    next_cycle();
    mid();
    check_eq("race_run", 32'(state_o), 32'(ST_RUN));

    // consecutive-stall timeout at 255 cycles
    next_cycle();
    ex_busy_i = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      mid();
      if (i == 1 || i == 255) check_eq("tmo_early", 32'(stall_timeout_o), 32'd0);
      next_cycle();
    end
    ex_busy_i = 1'b0;
    mid();
    check_eq("tmo_set", 32'(stall_timeout_o), 32'd1);
    check_eq("tmo_cnt", stall_cnt_o, 32'd260);
    repeat (3) next_cycle();
    mid();
    check_eq("tmo_sticky", 32'(stall_timeout_o), 32'd1);

    // reset in the middle of a FLUSH
    next_cycle();
    exc_valid_i = 1'b1; exc_pc_i = 32'h0000_0500;
    mid();
    check_eq("rf_ack", 32'(exc_ack_o), 32'd1);
    next_cycle();
    exc_valid_i = 1'b0; exc_pc_i = 32'd0;
    #1;
    check_eq("rf_pre_flush", 32'(flush_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_idle("rf_rst");
    check_eq("rf_state", 32'(state_o), 32'(ST_RUN));
    check_eq("rf_cnt", stall_cnt_o, 32'd0);
    check_eq("rf_tmo", 32'(stall_timeout_o), 32'd0);
    rst_i = 1'b0;
    mid();
    check_idle("rf_after");
    next_cycle();
    mid();
    check_idle("rf_after2");
    check_eq("rf_state2", 32'(state_o), 32'(ST_RUN));
    next_cycle();
    mem_stall_i = 1'b1;
    mid();
    check_eq("rf_mem_stall", 32'(stall_o), 32'(6'b011111));
    next_cycle();
    mem_stall_i = 1'b0;
    mid();
    check_eq("rf_cnt_restart", stall_cnt_o, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
